// File: rtl/ro_meter_pkg.sv
// rtl/ro_meter_pkg.sv - shared FSM encoding and default parameters for the ring-oscillator meter
package ro_meter_pkg;

   localparam int GATE_CYCLES_DEF   = 1000;
   localparam int WARMUP_CYCLES_DEF = 16;
   localparam int CNT_WIDTH_DEF     = 16;
   localparam int TIMER_WIDTH       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      GATE   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/ro_meter_ctrl_if.sv
// rtl/ro_meter_ctrl_if.sv - request/result bundle between a host and the ring-oscillator meter
interface ro_meter_ctrl_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 meas_start;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;

   modport master (
      output meas_start, abort,
      input  busy, done, count, overflow
   );

   modport slave (
      input  meas_start, abort,
      output busy, done, count, overflow
   );
endinterface

// File: rtl/ro_meter_ctrl_sync_edge_det.sv
// rtl/ro_meter_ctrl_sync_edge_det.sv - two-flop synchronizer plus rising-edge pulse for the oscillator input
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse = sync_q & ~prev_q;
endmodule

// File: rtl/ro_meter_ctrl.sv
// rtl/ro_meter_ctrl.sv - gated ring-oscillator edge counter; RO_METER_CONT_EN adds back-to-back windows via cont
import ro_meter_pkg::*;

module ro_meter_ctrl #(
   parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
   parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef RO_METER_CONT_EN
   input  logic              cont,
`endif
   input  logic              ro_clk,
   output logic              ro_start,
   ro_meter_ctrl_if.slave    bus
);
   localparam logic [TIMER_WIDTH-1:0] WARM_LOAD = TIMER_WIDTH'(WARMUP_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] GATE_LOAD = TIMER_WIDTH'(GATE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;

   state_t                 state_q, state_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0]   count_q;
   logic                   overflow_q;
   logic                   done_q;
   logic                   ro_start_q, ro_start_d;
   logic                   edge_pulse;
   logic                   cont_en;
   logic                   enter_gate;
   logic                   enter_done;

`ifdef RO_METER_CONT_EN
   assign cont_en = cont;
`else
   assign cont_en = 1'b0;
`endif

   sync_edge_det u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (ro_clk),
      .pulse    (edge_pulse)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            // abort outranks a simultaneous start request
            if (bus.meas_start && !bus.abort) begin
               state_d = WARMUP;
               timer_d = WARM_LOAD;
            end
         end
         WARMUP: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               state_d = GATE;
               timer_d = GATE_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         GATE: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               state_d = DONE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         DONE: begin
            if (cont_en && !bus.abort) begin
               state_d = GATE;
               timer_d = GATE_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_gate = (state_d == GATE) && (state_q != GATE);
   assign enter_done = (state_d == DONE) && (state_q != DONE);

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (enter_gate) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if ((state_q == GATE) && edge_pulse) begin
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // in continuous mode the oscillator keeps running through the one-cycle DONE
   assign ro_start_d = (state_d == WARMUP) || (state_d == GATE) ||
                       ((state_d == DONE) && cont_en);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         ro_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         done_q     <= enter_done;
         ro_start_q <= ro_start_d;
         if (enter_done) begin
            count_q    <= cnt_d;
            overflow_q <= ovf_d;
         end
      end
   end

   assign ro_start     = ro_start_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
endmodule

// File: doc/ro_meter_ctrl.md
RO_METER_CTRL -- requirements
Module: ro_meter_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 1000, giving the measurement window length in clk cycles (range 2..65535).
REQ-002 The block SHALL have parameter WARMUP_CYCLES, default 16, giving the oscillator settle time in clk cycles before counting (range 1..255).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the edge-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port meas_start, input, 1 bit: single-cycle request to run one measurement.
REQ-007 The block SHALL have port abort, input, 1 bit: aborts any measurement in progress.
REQ-008 The block SHALL have port ro_clk, input, 1 bit: oscillator output, asynchronous to clk.
REQ-009 The block SHALL have port ro_start, output, 1 bit: enable driven to the ring-oscillator AND gate.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-012 The block SHALL have port count, output, CNT_WIDTH bits: number of ro_clk rising edges counted in the last completed window.
REQ-013 The block SHALL have port overflow, output, 1 bit: the last window saturated the counter.

Function
REQ-014 FSM states SHALL be IDLE, WARMUP, GATE and DONE.
REQ-015 IDLE->WARMUP SHALL occur on meas_start=1; meas_start SHALL be ignored in every other state.
REQ-016 WARMUP SHALL last exactly WARMUP_CYCLES cycles and then go to GATE.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles and then go to DONE.
REQ-018 DONE SHALL last one cycle and then go to IDLE.
REQ-019 ro_start SHALL be registered and be high exactly while the state is WARMUP or GATE.
REQ-020 ro_clk SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; each detected edge pulse occurring while in GATE SHALL increment the internal counter by 1.
REQ-021 The internal counter SHALL clear on the WARMUP->GATE transition.
REQ-022 The internal counter SHALL saturate at 2^CNT_WIDTH-1; further edges SHALL set an internal overflow flag.
REQ-023 On entry to DONE, count and overflow SHALL be loaded from the internal counter and flag; done SHALL be 1 for that single cycle.
REQ-024 count and overflow SHALL hold their values until the next DONE.
REQ-025 abort=1 in WARMUP or GATE SHALL force IDLE on the next edge, drop ro_start on that same edge, produce no done, and leave count/overflow unchanged.
REQ-026 When abort and meas_start are both high in IDLE, abort SHALL win and the state SHALL remain IDLE.
REQ-027 The synchronizer latency SHALL be accepted as a documented uncertainty of ±1 edge per window.

Reset
REQ-028 When rst_n=0 at a clk edge, the state SHALL go to IDLE and ro_start, busy, done, count, overflow, the internal counter and the synchronizer flops SHALL all go to 0.
REQ-029 Reset asserted mid-measurement SHALL stop the oscillator (ro_start=0) on the same edge and produce no done.

Configuration
REQ-030 When macro RO_METER_CONT_EN is defined, input cont (1 bit) SHALL be added; with cont=1, DONE SHALL go directly to GATE, ro_start SHALL stay high, and the counter SHALL clear, so that back-to-back windows produce periodic done pulses.
REQ-031 When RO_METER_CONT_EN is not defined, the cont port SHALL be absent and behaviour SHALL be single-shot as specified above; ro_start SHALL drop in DONE.

Structure
REQ-032 Package ro_meter_pkg SHALL hold the FSM state enum (2-bit encoding) and default constants for GATE_CYCLES, WARMUP_CYCLES and CNT_WIDTH.
REQ-033 The synchronizer and edge detector SHALL be a sub-module named sync_edge_det; the FSM and counters SHALL stay in ro_meter_ctrl.

Verification
REQ-034 Bench: 100 MHz clk, 5 MHz ro_clk model gated by ro_start, meas_start pulse -> ro_start high after 1 cycle, done after 1+16+1000 cycles, count = 50 ±1, overflow=0.
REQ-035 Bench: abort pulsed at GATE cycle 300 -> ro_start=0 and busy=0 on the next cycle, no done, count keeps its previous value.
REQ-036 Bench: CNT_WIDTH=4 with 5 MHz ro_clk -> count=15, overflow=1 at done.
REQ-037 Bench: meas_start re-pulsed during GATE, and meas_start with abort in IDLE -> both ignored, exactly one done per accepted start.
REQ-038 Bench: rst_n=0 in WARMUP -> all outputs 0 on the next edge; after release, a fresh measurement yields count = 50 ±1.
REQ-039 Bench: with RO_METER_CONT_EN defined and cont=1 -> done pulses every 1001 cycles, ro_start never drops, each count = 50 ±1.
